// File: rtl/cube_pkg.sv
// Shared constants and FSM state type for the LED cube frame buffer.
// Pixel address is {layer, y, x}; pixel data is {red, green, blue}.
package cube_pkg;
    localparam int PIXEL_ADDR_W = 12;
    localparam int PIXEL_W      = 24;
    localparam int CUBE_DIM     = 16;

    localparam int X_LSB     = 0;
    localparam int Y_LSB     = 4;
    localparam int LAYER_LSB = 8;
    localparam int BLUE_LSB  = 0;
    localparam int GREEN_LSB = 8;
    localparam int RED_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PENDING = 2'd2
    } fb_state_e;
endpackage

// File: rtl/cube_frame_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Array contents are not reset; only the read output register is.
module cube_frame_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/cube_frame_buffer.sv
// Double-buffered pixel store: host writes the back bank, controller reads
// the front bank, and banks swap only on a controller frame boundary.
module cube_frame_buffer
    import cube_pkg::*;
#(
    parameter int ADDR_W = PIXEL_ADDR_W,
    parameter int DATA_W = PIXEL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              clear_req,
    output logic              busy,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              swapped,
    output logic              front_bank,
    output logic [1:0]        fsm_state
);
    // Handshake: a pixel write happens on a rising edge where wr_valid && wr_ready.
    fb_state_e         state_q, state_d;
    logic              init_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              front_bank_q;
    logic              swapped_q;
    logic              swap;
    logic              ram_we;
    logic [ADDR_W:0]   ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            init_q       <= 1'b0;
            clr_cnt_q    <= '0;
            front_bank_q <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= 1'b1;
            clr_cnt_q    <= (state_q == CLEAR) ? clr_cnt_q + 1'b1 : '0;
            front_bank_q <= front_bank_q ^ swap;
            swapped_q    <= swap;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ready  = 1'b0;
        swap      = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = {~front_bank_q, wr_addr};
        ram_wdata = wr_data;
        case (state_q)
            IDLE: begin
                // The first cycle after reset is held off so nothing is accepted yet.
                wr_ready = init_q;
                if (init_q) begin
                    ram_we = wr_valid;
                    if (clear_req) begin
                        state_d = CLEAR;
                    end else if (commit) begin
                        state_d = PENDING;
                    end
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = {~front_bank_q, clr_cnt_q};
                ram_wdata = '0;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    cube_frame_ram #(
        .ADDR_W(ADDR_W + 1),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  ({front_bank_q, rd_addr}),
        .rdata  (rd_data)
    );

    assign busy       = !init_q || (state_q != IDLE);
    assign swapped    = swapped_q;
    assign front_bank = front_bank_q;
    assign fsm_state  = state_q;
endmodule

// File: tb/tb_cube_frame_buffer.sv
// Directed self-checking bench for cube_frame_buffer.
module tb_cube_frame_buffer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        frame_start = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [23:0] rd_data;
    logic        swapped;
    logic        front_bank;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    cube_frame_buffer dut (
        .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .clear_req(clear_req),
        .busy(busy), .frame_start(frame_start), .rd_addr(rd_addr), .rd_data(rd_data),
        .swapped(swapped), .front_bank(front_bank), .fsm_state(fsm_state)
    );

    always #10 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_px(input logic [11:0] a, input logic [23:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_clear();
        int busy_low;
        busy_low = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 4095; i++) begin
            if (busy !== 1'b1 || wr_ready !== 1'b0) busy_low++;
            tick();
        end
        if (busy !== 1'b1) busy_low++;
        check("clear_busy_4096", busy_low, 0);
        tick();
        check("clear_done_busy", busy, 0);
        check("clear_done_ready", wr_ready, 1);
    endtask

    task automatic do_swap(input logic exp_fb);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("pending_busy", busy, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("swap_front_bank", front_bank, exp_fb);
        check("swap_pulse", swapped, 1);
        tick();
        check("swap_pulse_end", swapped, 0);
    endtask

    task automatic read_px(input string tag, input logic [11:0] a, input logic [23:0] exp);
        rd_addr = a;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        // Reset state
        #35;
        check("rst_ready", wr_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_rd_data", rd_data, 0);
        check("rst_swapped", swapped, 0);
        check("rst_front", front_bank, 0);
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_busy", busy, 1);
        check("post_rst_ready", wr_ready, 0);
        tick();
        check("init_busy", busy, 0);
        check("init_ready", wr_ready, 1);

        // Clear bank 1, show it, read zeros
        do_clear();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("pending_ready", wr_ready, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("first_swap_front", front_bank, 1);
        check("first_swap_pulse", swapped, 1);
        tick();
        check("first_swap_pulse_end", swapped, 0);
        read_px("clr_rd_0", 12'h000, 24'h0);
        read_px("clr_rd_2048", 12'h800, 24'h0);
        read_px("clr_rd_4095", 12'hFFF, 24'h0);

        // Clear bank 0, write red pixel, swap, read it back
        do_clear();
        write_px(12'h123, 24'hFF0000);
        write_px(12'h010, 24'h0000AA);
        do_swap(1'b0);
        read_px("red_px", 12'h123, 24'hFF0000);
        read_px("blue_px", 12'h010, 24'h0000AA);

        // Read in the swapping frame_start cycle uses the old bank
        write_px(12'h010, 24'h0000BB);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        rd_addr = 12'h010;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_read_old_bank", rd_data, 24'h0000AA);
        check("fs_front", front_bank, 1);
        tick();
        check("fs_next_read_new", rd_data, 24'h0000BB);

        // Commit together with frame_start: swap waits for the next frame_start
        commit = 1'b1;
        frame_start = 1'b1;
        tick();
        commit = 1'b0;
        frame_start = 1'b0;
        check("coinc_no_swap", front_bank, 1);
        check("coinc_no_pulse", swapped, 0);
        check("coinc_pending", busy, 1);
        for (int i = 0; i < 9; i++) tick();
        check("coinc_still_pending", busy, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("coinc_late_swap", front_bank, 0);
        check("coinc_late_pulse", swapped, 1);

        // Write held during PENDING lands in the new back bank after the swap
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_valid = 1'b1; wr_addr = 12'h050; wr_data = 24'h00FF00;
        tick();
        check("pend_hold_ready", wr_ready, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pend_swap_front", front_bank, 1);
        check("pend_ready_back", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        read_px("held_not_shown", 12'h050, 24'h0);
        do_swap(1'b0);
        read_px("held_shown", 12'h050, 24'h00FF00);

        // Reset at clear cycle 100 leaves upper addresses of bank 1 intact
        write_px(12'h032, 24'hABCDEF);
        write_px(12'h064, 24'h123456);
        write_px(12'hFA0, 24'h654321);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1);
        check("midrst_front", front_bank, 0);
        tick();
        reset_n = 1'b1;
        #1;
        check("midrst_rel_busy", busy, 1);
        tick();
        check("midrst_busy_low", busy, 0);
        check("midrst_ready", wr_ready, 1);
        check("midrst_front_after", front_bank, 0);
        do_swap(1'b1);
        read_px("midrst_cleared_50", 12'h032, 24'h0);
        read_px("midrst_kept_100", 12'h064, 24'h123456);
        read_px("midrst_kept_4000", 12'hFA0, 24'h654321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
